// File: rtl/matrix_alu_responder.sv
// matrix_alu_responder: bus-mapped 4x4x16-bit matrix ALU (add, sub, transpose, scale) in a 16-address window.
module matrix_alu_responder #(
  parameter logic [15:0] BASE_ADDR = 16'h2010,
  parameter int ROWS_PER_CYCLE = 4
) (
  input  logic         Clk,
  input  logic         nReset,
  input  logic         nRead,
  input  logic         nWrite,
  input  logic [15:0]  address,
  input  logic [255:0] ExeDataOut,
  output logic [255:0] MatrixDataOut,
  output logic         Busy,
  output logic         Complete
);
  localparam logic [2:0] STEP = 3'(ROWS_PER_CYCLE);
  localparam logic [1:0] OP_SUB = 2'b00, OP_TR = 2'b01, OP_SC = 2'b10;
  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;
  state_t       r_state;
  logic [255:0] r_src1, r_src2, r_result;
  logic [1:0]   r_op;
  logic [2:0]   r_row;
  logic         r_prev_cmd;
  logic [3:0]   r_prev_sel;
  logic [15:0]  w_off;
  logic [3:0]   w_sel;
  logic         w_in_win, w_wr, w_rd, w_cmd_wr, w_trigger, w_last;
  logic [255:0] w_full, w_next, w_rd_data;
  assign w_off     = address - BASE_ADDR;
  assign w_in_win  = w_off[15:4] == 12'h000;
  assign w_sel     = w_off[3:0];
  assign w_wr      = !nWrite && w_in_win;
  assign w_rd      = !nRead && nWrite && w_in_win;
  assign w_cmd_wr  = w_wr && w_sel >= 4'd3 && w_sel <= 4'd6;
  // a command fires only on the first cycle of a held write to that command address
  assign w_trigger = w_cmd_wr && !(r_prev_cmd && r_prev_sel == w_sel) && r_state != COMPUTE;
  assign w_last    = r_row + STEP == 3'd4;
  for (genvar e = 0; e < 16; e++) begin : g_el
    logic [15:0] w_a, w_b;
    assign w_a = r_src1[16*e +: 16];
    assign w_b = r_src2[16*e +: 16];
    assign w_full[16*e +: 16] = r_op == OP_SUB ? w_a - w_b :
                                r_op == OP_TR  ? r_src1[16*(4*(e%4)+e/4) +: 16] :
                                r_op == OP_SC  ? w_a * r_src2[15:0] : w_a + w_b;
  end
  for (genvar r = 0; r < 4; r++) begin : g_row
    assign w_next[64*r +: 64] = (3'(r) >= r_row && 3'(r) < r_row + STEP) ? w_full[64*r +: 64] : r_result[64*r +: 64];
  end
  // a RESULT read on the final compute edge sees the freshly computed value
  assign w_rd_data = w_sel == 4'd0 ? r_src1 :
                     w_sel == 4'd1 ? r_src2 :
                     w_sel == 4'd2 ? ((r_state == COMPUTE && w_last) ? w_next : r_result) : '0;
  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      r_state       <= IDLE;
      r_src1        <= '0;
      r_src2        <= '0;
      r_result      <= '0;
      r_op          <= '0;
      r_row         <= '0;
      r_prev_cmd    <= 1'b0;
      r_prev_sel    <= '0;
      MatrixDataOut <= '0;
      Busy          <= 1'b0;
      Complete      <= 1'b0;
    end else begin
      r_prev_cmd <= w_cmd_wr;
      r_prev_sel <= w_sel;
      Complete   <= 1'b0;
      if (w_wr && !Busy && w_sel == 4'd0) r_src1 <= ExeDataOut;
      if (w_wr && !Busy && w_sel == 4'd1) r_src2 <= ExeDataOut;
      if (w_rd) MatrixDataOut <= w_rd_data;
      case (r_state)
        COMPUTE: begin
          r_result <= w_next;
          r_row    <= r_row + STEP;
          if (w_last) begin
            r_state  <= DONE;
            Busy     <= 1'b0;
            Complete <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          if (w_trigger) begin
            r_op    <= w_sel[1:0];
            r_row   <= '0;
            Busy    <= 1'b1;
            r_state <= COMPUTE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_matrix_alu_responder.sv
// tb_matrix_alu_responder: drives both a one-cycle and a four-cycle responder from one bus and scores reads against a model.
module tb_matrix_alu_responder;
  localparam logic [15:0] B = 16'h2010;
  logic         Clk = 1'b0, nReset = 1'b0, nRead = 1'b1, nWrite = 1'b1;
  logic [15:0]  address = '0;
  logic [255:0] ExeDataOut = '0;
  logic [255:0] MatrixDataOut, MatrixDataOut1;
  logic         Busy, Busy1, Complete, Complete1;
  int           vectors = 0, miscompares = 0;
  int           c0 = 0, c1 = 0, b1 = 0;
  logic [255:0] exp_q[$];
  matrix_alu_responder #(.BASE_ADDR(B), .ROWS_PER_CYCLE(4)) dut (
    .Clk(Clk), .nReset(nReset), .nRead(nRead), .nWrite(nWrite), .address(address),
    .ExeDataOut(ExeDataOut), .MatrixDataOut(MatrixDataOut), .Busy(Busy), .Complete(Complete));
  matrix_alu_responder #(.BASE_ADDR(B), .ROWS_PER_CYCLE(1)) dut1 (
    .Clk(Clk), .nReset(nReset), .nRead(nRead), .nWrite(nWrite), .address(address),
    .ExeDataOut(ExeDataOut), .MatrixDataOut(MatrixDataOut1), .Busy(Busy1), .Complete(Complete1));
  always #5 Clk = ~Clk;
  always @(negedge Clk) begin
    if (Complete) c0++;
    if (Complete1) c1++;
    if (Busy1) b1++;
  end
  function automatic logic [255:0] ramp();
    logic [255:0] v;
    for (int i = 0; i < 16; i++) v[16*i +: 16] = 16'(i);
    return v;
  endfunction
  function automatic logic [255:0] fill(input logic [15:0] x);
    return {16{x}};
  endfunction
  function automatic logic [255:0] model(input int op, input logic [255:0] a, input logic [255:0] b);
    logic [255:0] res;
    res = '0;
    for (int row = 0; row < 4; row++)
      for (int col = 0; col < 4; col++) begin
        logic [15:0] x, y, t;
        x = a[16*(4*row+col) +: 16];
        y = b[16*(4*row+col) +: 16];
        t = a[16*(4*col+row) +: 16];
        case (op)
          0: res[16*(4*row+col) +: 16] = x + y;
          1: res[16*(4*row+col) +: 16] = x - y;
          2: res[16*(4*row+col) +: 16] = t;
          default: res[16*(4*row+col) +: 16] = 16'(x * b[15:0]);
        endcase
      end
    return res;
  endfunction
  task automatic wr(input logic [3:0] off, input logic [255:0] d, input int n);
    @(posedge Clk); #1;
    nWrite = 1'b0; address = B + 16'(off); ExeDataOut = d;
    repeat (n) @(posedge Clk);
    #1 nWrite = 1'b1; address = '0;
  endtask
  task automatic rd(input logic [3:0] off, input bit which, input string name, output logic [255:0] got);
    logic [255:0] exp;
    @(posedge Clk); #1;
    nRead = 1'b0; address = B + 16'(off);
    @(posedge Clk); #1 nRead = 1'b1; address = '0;
    @(negedge Clk);
    got = which ? MatrixDataOut1 : MatrixDataOut;
    exp = exp_q.size() ? exp_q.pop_front() : 'x;
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic cmd(input int op, input logic [255:0] a, input logic [255:0] b);
    exp_q.push_back(model(op, a, b));
    wr(4'(3 + op), '0, 2);
    repeat (6) @(posedge Clk);
  endtask
  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic test_reset();
    logic [255:0] g;
    #12;
    chk("reset_data", MatrixDataOut, '0);
    chk("reset_busy", {Busy1, Busy}, '0);
    chk("reset_complete", {Complete1, Complete}, '0);
    repeat (2) @(posedge Clk);
    #1 nReset = 1'b1;
    exp_q.push_back('0);
    rd(2, 0, "reset_result", g);
  endtask
  task automatic test_add();
    logic [255:0] g;
    int n;
    wr(0, ramp(), 2);
    wr(1, fill(16'h0100), 2);
    n = c0;
    cmd(0, ramp(), fill(16'h0100));
    chk("add_complete_pulses", 256'(c0 - n), 256'(1));
    rd(2, 0, "add_result", g);
    chk("add_elem7", 256'(g[16*7 +: 16]), 256'(16'h0107));
  endtask
  task automatic test_sub();
    logic [255:0] g;
    wr(0, fill(16'h0001), 2);
    wr(1, fill(16'h0003), 2);
    cmd(1, fill(16'h0001), fill(16'h0003));
    rd(2, 0, "sub_wrap", g);
    chk("sub_elem0", 256'(g[15:0]), 256'(16'hFFFE));
  endtask
  task automatic test_transpose_scale();
    logic [255:0] g, s2;
    s2 = {{15{16'h5A5A}}, 16'h1000};
    wr(0, ramp(), 2);
    wr(1, s2, 2);
    cmd(2, ramp(), s2);
    rd(2, 0, "transpose", g);
    chk("tr_elems", {g[16*1 +: 16], g[16*4 +: 16], g[16*15 +: 16]}, {16'd4, 16'd1, 16'd15});
    cmd(3, ramp(), s2);
    rd(2, 0, "scale", g);
    chk("scale_elems", {g[15:0], g[16*15 +: 16]}, {16'h0000, 16'hF000});
  endtask
  task automatic test_held_cmd();
    logic [255:0] g;
    int n1, nb;
    wr(1, fill(16'h0007), 2);
    n1 = c1; nb = b1;
    exp_q.push_back(model(0, ramp(), fill(16'h0007)));
    @(posedge Clk); #1;
    nWrite = 1'b0; address = B + 16'h3;
    repeat (3) @(posedge Clk);
    #1 address = B + 16'h4;
    @(posedge Clk);
    #1 address = B; ExeDataOut = '1;
    @(posedge Clk);
    #1 nWrite = 1'b1; address = '0;
    repeat (6) @(posedge Clk);
    chk("held_complete_pulses", 256'(c1 - n1), 256'(1));
    chk("held_busy_cycles", 256'(b1 - nb), 256'(4));
    rd(2, 1, "held_result", g);
    exp_q.push_back(ramp());
    rd(0, 1, "busy_src1_write_dropped", g);
  endtask
  task automatic test_forwarding();
    logic [255:0] g;
    wr(0, fill(16'h0005), 2);
    wr(1, fill(16'h0002), 2);
    wr(3, '0, 2);
    repeat (6) @(posedge Clk);
    exp_q.push_back(model(1, fill(16'h0005), fill(16'h0002)));
    @(posedge Clk); #1;
    nWrite = 1'b0; address = B + 16'h4;
    @(posedge Clk); #1;
    nWrite = 1'b1; nRead = 1'b0; address = B + 16'h2;
    @(posedge Clk); #1 nRead = 1'b1; address = '0;
    @(negedge Clk);
    g = exp_q.pop_front();
    chk("forwarded_result", MatrixDataOut, g);
    repeat (6) @(posedge Clk);
    exp_q.push_back('0);
    rd(9, 0, "reserved_read", g);
    @(posedge Clk); #1;
    nRead = 1'b0; nWrite = 1'b0; address = B; ExeDataOut = fill(16'hABCD);
    repeat (2) @(posedge Clk);
    #1 nRead = 1'b1; nWrite = 1'b1; address = '0;
    @(negedge Clk);
    chk("conflict_read_ignored", MatrixDataOut, '0);
    exp_q.push_back(fill(16'hABCD));
    rd(0, 0, "conflict_write_done", g);
  endtask
  task automatic test_reset_mid();
    logic [255:0] g;
    int n1;
    wr(0, ramp(), 2);
    exp_q.push_back(ramp());
    rd(0, 1, "pre_reset_src1", g);
    n1 = c1;
    @(posedge Clk); #1;
    nWrite = 1'b0; address = B + 16'h3;
    @(posedge Clk); #1 nWrite = 1'b1; address = '0;
    @(posedge Clk); #1;
    chk("mid_busy_before_reset", 256'(Busy1), 256'(1));
    nReset = 1'b0;
    #1;
    chk("async_reset_outputs", {MatrixDataOut1, Busy1, Complete1}, '0);
    repeat (3) @(posedge Clk);
    #1 nReset = 1'b1;
    repeat (6) @(posedge Clk);
    chk("abort_no_complete", 256'(c1 - n1), 256'(0));
    chk("abort_idle", 256'(Busy1), 256'(0));
    exp_q.push_back('0);
    rd(2, 1, "abort_result_cleared", g);
  endtask
  initial begin
    fork
      begin
        test_reset();
        test_add();
        test_sub();
        test_transpose_scale();
        test_held_cmd();
        test_forwarding();
        test_reset_mid();
      end
      begin
        #200000;
        miscompares++;
        $display("FAIL timeout: sequence not done within 200000 time units");
      end
    join_any
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
